// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
// Module   : program_loader
// Brief    : Parses framed load packets (SYNC, ADDR, LEN, data..., CSUM) from
//            a byte stream and issues one program-memory write per data byte,
//            holding the CPU while a load is in progress.
//            Optional inter-byte timeout enabled by defining LOADER_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module program_loader #(
    parameter int          TIMEOUT_CYCLES = 100000,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       mem_we,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    output logic       cpu_hold,
    output logic       load_done,
    output logic       load_error,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_GET_ADDR = 3'd1,
        S_GET_LEN  = 3'd2,
        S_GET_DATA = 3'd3,
        S_GET_CSUM = 3'd4,
        S_ERROR    = 3'd5
    } state_t;

    state_t     r_state;
    logic [7:0] r_base;
    logic [8:0] r_count;       // 1..256 data bytes
    logic [8:0] r_index;
    logic [7:0] r_sum;
    logic       r_mem_we;
    logic [7:0] r_mem_addr;
    logic [7:0] r_mem_wdata;
    logic       r_load_done;
    logic       r_load_error;

    // Running sum including the current byte; wraps at 8 bits by width.
    logic [7:0] w_sum_next;
    logic       w_last_data;
    logic       w_sync;

    assign w_sum_next  = r_sum + rx_data;
    assign w_last_data = ((r_index + 9'd1) == r_count);
    assign w_sync      = rx_valid && (rx_data == SYNC_BYTE);

`ifdef LOADER_TIMEOUT_EN
    localparam int                c_TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT_CYCLES - 1);

    logic [c_TMO_W-1:0] r_tmo;
    logic               w_in_frame;

    assign w_in_frame = (r_state == S_GET_ADDR) || (r_state == S_GET_LEN) ||
                        (r_state == S_GET_DATA) || (r_state == S_GET_CSUM);
`endif

    // Frame parser FSM with registered write strobe, status and data outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_base       <= 8'd0;
            r_count      <= 9'd0;
            r_index      <= 9'd0;
            r_sum        <= 8'd0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= 8'd0;
            r_mem_wdata  <= 8'd0;
            r_load_done  <= 1'b0;
            r_load_error <= 1'b0;
`ifdef LOADER_TIMEOUT_EN
            r_tmo        <= '0;
`endif
        end else begin
            r_mem_we    <= 1'b0;
            r_load_done <= 1'b0;

            case (r_state)
                // IDLE and ERROR both wait for a SYNC; anything else is dropped.
                S_IDLE, S_ERROR: begin
                    if (w_sync) begin
                        r_state      <= S_GET_ADDR;
                        r_load_error <= 1'b0;
                    end
                end
                S_GET_ADDR: begin
                    if (rx_valid) begin
                        r_base  <= rx_data;
                        r_sum   <= rx_data;
                        r_state <= S_GET_LEN;
                    end
                end
                S_GET_LEN: begin
                    if (rx_valid) begin
                        // A zero length byte encodes a full 256-byte page.
                        r_count <= {(rx_data == 8'd0), rx_data};
                        r_sum   <= w_sum_next;
                        r_index <= 9'd0;
                        r_state <= S_GET_DATA;
                    end
                end
                S_GET_DATA: begin
                    if (rx_valid) begin
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= r_base + r_index[7:0];
                        r_mem_wdata <= rx_data;
                        r_sum       <= w_sum_next;
                        r_index     <= r_index + 9'd1;
                        if (w_last_data) begin
                            r_state <= S_GET_CSUM;
                        end
                    end
                end
                S_GET_CSUM: begin
                    if (rx_valid) begin
                        if (w_sum_next == 8'd0) begin
                            r_state     <= S_IDLE;
                            r_load_done <= 1'b1;
                        end else begin
                            r_state      <= S_ERROR;
                            r_load_error <= 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase

`ifdef LOADER_TIMEOUT_EN
            // Inter-byte watchdog: any received byte restarts it; it only runs
            // while a frame is open and forces ERROR when the gap is too long.
            if (!w_in_frame || rx_valid) begin
                r_tmo <= '0;
            end else if (r_tmo == c_TMO_LAST) begin
                r_tmo        <= '0;
                r_state      <= S_ERROR;
                r_load_error <= 1'b1;
            end else begin
                r_tmo <= r_tmo + 1'b1;
            end
`endif
        end
    end

    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign load_done  = r_load_done;
    assign load_error = r_load_error;
    assign busy       = (r_state != S_IDLE);
    assign cpu_hold   = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_program_loader
// Brief    : Directed self-checking bench for program_loader.
// Revision : 1.0 - initial release
// ============================================================================
module tb_program_loader;

    logic       clk;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       cpu_hold;
    logic       load_done;
    logic       load_error;
    logic       busy;

    int tests;
    int fails;
    int wr_count;

    program_loader #(
        .TIMEOUT_CYCLES (16),
        .SYNC_BYTE      (8'hA5)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .cpu_hold   (cpu_hold),
        .load_done  (load_done),
        .load_error (load_error),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Total write strobes seen, sampled mid-cycle.
    always @(negedge clk) begin
        if (mem_we === 1'b1) wr_count <= wr_count + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one byte for one cycle; returns 1ns after the capturing edge.
    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic check_write(input string tag, input logic [7:0] a, input logic [7:0] d);
        check({tag, "_we"},   {31'd0, mem_we}, 32'd1);
        check({tag, "_addr"}, {24'd0, mem_addr}, {24'd0, a});
        check({tag, "_data"}, {24'd0, mem_wdata}, {24'd0, d});
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_we"},    {31'd0, mem_we},     32'd0);
        check({tag, "_addr"},  {24'd0, mem_addr},   32'd0);
        check({tag, "_wdata"}, {24'd0, mem_wdata},  32'd0);
        check({tag, "_hold"},  {31'd0, cpu_hold},   32'd0);
        check({tag, "_done"},  {31'd0, load_done},  32'd0);
        check({tag, "_err"},   {31'd0, load_error}, 32'd0);
        check({tag, "_busy"},  {31'd0, busy},       32'd0);
    endtask

    initial begin
        tests    = 0;
        fails    = 0;
        wr_count = 0;
        reset    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;

        // 1: reset, then stray bytes in IDLE are ignored
        repeat (2) @(posedge clk);
        #1;
        check_idle_outputs("rst");
        reset = 1'b1;
        send(8'h00);
        check("idle_00_we",   {31'd0, mem_we}, 32'd0);
        check("idle_00_busy", {31'd0, busy},   32'd0);
        send(8'h13);
        check("idle_13_we",   {31'd0, mem_we}, 32'd0);
        check("idle_13_busy", {31'd0, busy},   32'd0);

        // 2: good frame A5,10,02,70,80,FE
        send(8'hA5);
        check("f2_sync_hold", {31'd0, cpu_hold}, 32'd1);
        check("f2_sync_busy", {31'd0, busy},     32'd1);
        send(8'h10);
        send(8'h02);
        check("f2_len_we", {31'd0, mem_we}, 32'd0);
        send(8'h70);
        check_write("f2_w0", 8'h10, 8'h70);
        send(8'h80);
        check_write("f2_w1", 8'h11, 8'h80);
        send(8'hFE);
        check("f2_done",    {31'd0, load_done},  32'd1);
        check("f2_hold",    {31'd0, cpu_hold},   32'd0);
        check("f2_busy",    {31'd0, busy},       32'd0);
        check("f2_err",     {31'd0, load_error}, 32'd0);
        check("f2_csum_we", {31'd0, mem_we},     32'd0);
        @(posedge clk); #1;
        check("f2_done_pulse", {31'd0, load_done}, 32'd0);

        // 3: address wrap A5,FF,02,11,22,CC
        send(8'hA5);
        send(8'hFF);
        send(8'h02);
        send(8'h11);
        check_write("f3_w0", 8'hFF, 8'h11);
        send(8'h22);
        check_write("f3_w1", 8'h00, 8'h22);
        send(8'hCC);
        check("f3_done", {31'd0, load_done}, 32'd1);
        check("f3_hold", {31'd0, cpu_hold},  32'd0);

        // 4: bad checksum, stray byte in ERROR, then recovery with a good frame
        send(8'hA5);
        send(8'h10);
        send(8'h02);
        send(8'h70);
        check_write("f4_w0", 8'h10, 8'h70);
        send(8'h80);
        check_write("f4_w1", 8'h11, 8'h80);
        send(8'h00);
        check("f4_done", {31'd0, load_done},  32'd0);
        check("f4_err",  {31'd0, load_error}, 32'd1);
        check("f4_hold", {31'd0, cpu_hold},   32'd1);
        send(8'h55);
        check("f4_stray_we",  {31'd0, mem_we},     32'd0);
        check("f4_stray_err", {31'd0, load_error}, 32'd1);
        send(8'hA5);
        check("f4_resync_err",  {31'd0, load_error}, 32'd0);
        check("f4_resync_hold", {31'd0, cpu_hold},   32'd1);
        send(8'h10);
        send(8'h02);
        send(8'h70);
        send(8'h80);
        send(8'hFE);
        check("f4_rec_done", {31'd0, load_done},  32'd1);
        check("f4_rec_err",  {31'd0, load_error}, 32'd0);

        // 5: SYNC value as address, reset mid-data, next byte must not write
        send(8'hA5);
        send(8'hA5);
        send(8'h02);
        send(8'h70);
        check_write("f5_w0", 8'hA5, 8'h70);
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        check_idle_outputs("f5_rst");
        send(8'h80);
        check("f5_after_we",   {31'd0, mem_we}, 32'd0);
        check("f5_after_busy", {31'd0, busy},   32'd0);

        check("write_total", wr_count, 32'd9);

        // 6: stalled frame after A5,10
        send(8'hA5);
        send(8'h10);
`ifdef LOADER_TIMEOUT_EN
        repeat (15) @(posedge clk);
        #1;
        check("f6_pre_err", {31'd0, load_error}, 32'd0);
        @(posedge clk); #1;
        check("f6_err",  {31'd0, load_error}, 32'd1);
        check("f6_hold", {31'd0, cpu_hold},   32'd1);
`else
        repeat (1000) @(posedge clk);
        #1;
        check("f6_busy", {31'd0, busy},       32'd1);
        check("f6_err",  {31'd0, load_error}, 32'd0);
`endif
        check("f6_no_writes", wr_count, 32'd9);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
